// File: rtl/lane_bit_write_pkg.sv
// -----------------------------------------------------------------------------
// lane_bit_write_pkg
// Shared types and helpers for the lane_bit_write_reg register bank.
//   lane_op_e  : per-lane operation selector (LOAD / SET / CLR / TGL)
//   MAX_LANE_W : widest lane the apply_op helper can process
//   apply_op   : combines the current lane value with a data/mask word
// -----------------------------------------------------------------------------
package lane_bit_write_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_SET  = 2'd1,
    OP_CLR  = 2'd2,
    OP_TGL  = 2'd3
  } lane_op_e;

  localparam int MAX_LANE_W = 32;

  // Lane values are zero-extended to MAX_LANE_W by the caller, so one
  // function serves every lane width.
  function automatic logic [MAX_LANE_W-1:0] apply_op(
    input logic [MAX_LANE_W-1:0] cur,
    input logic [MAX_LANE_W-1:0] mask,
    input lane_op_e              op
  );
    logic [MAX_LANE_W-1:0] res;
    case (op)
      OP_LOAD: res = mask;
      OP_SET:  res = cur | mask;
      OP_CLR:  res = cur & ~mask;
      OP_TGL:  res = cur ^ mask;
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lane_bit_write_slice.sv
// -----------------------------------------------------------------------------
// lane_bit_write_slice
// One lane of the register bank: holds LANE_W bits plus the lane dirty flag.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr_i           synchronous clear of the lane to RST_VAL (highest priority)
//   we_i, op_i      lane operation enable and operation select
//   d_i             data/mask for the lane operation
//   bit_hit_i       decoded single-bit write hits, one per lane bit
//   bit_val_i       value written on a bit hit
//   dirty_clr_i     clear request for the dirty flag
//   q_o, dirty_o    registered lane value and dirty flag
// -----------------------------------------------------------------------------
module lane_bit_write_slice
  import lane_bit_write_pkg::*;
#(
  parameter int                LANE_W  = 4,
  parameter logic [LANE_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  lane_op_e          op_i,
  input  logic [LANE_W-1:0] d_i,
  input  logic [LANE_W-1:0] bit_hit_i,
  input  logic              bit_val_i,
  input  logic              dirty_clr_i,
  output logic [LANE_W-1:0] q_o,
  output logic              dirty_o
);

  if (LANE_W > MAX_LANE_W || LANE_W < 1) begin : g_bad_lane_w
    $error("lane_bit_write_slice: LANE_W out of supported range");
  end

  logic [LANE_W-1:0]     lane_q;
  logic [LANE_W-1:0]     lane_d;
  logic                  dirty_q;
  logic                  dirty_d;
  logic [MAX_LANE_W-1:0] cur_ext_s;
  logic [MAX_LANE_W-1:0] mask_ext_s;
  logic [LANE_W-1:0]     op_res_s;

  // Next lane value: clear beats everything, a bit hit beats the lane op.
  always_comb begin
    cur_ext_s                = '0;
    cur_ext_s[LANE_W-1:0]    = lane_q;
    mask_ext_s               = '0;
    mask_ext_s[LANE_W-1:0]   = d_i;
    op_res_s                 = LANE_W'(apply_op(cur_ext_s, mask_ext_s, op_i));
    lane_d                   = lane_q;
    if (clr_i) begin
      lane_d = RST_VAL;
    end else begin
      for (int k = 0; k < LANE_W; k++) begin
        if (bit_hit_i[k]) begin
          lane_d[k] = bit_val_i;
        end else if (we_i) begin
          lane_d[k] = op_res_s[k];
        end else begin
          lane_d[k] = lane_q[k];
        end
      end
    end
    // A change in this cycle sets the flag even if a clear is requested.
    dirty_d = (lane_d != lane_q) | (dirty_q & ~dirty_clr_i);
  end

  // Lane storage and dirty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= RST_VAL;
      dirty_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      dirty_q <= dirty_d;
    end
  end

  assign q_o     = lane_q;
  assign dirty_o = dirty_q;

endmodule

// File: rtl/lane_bit_write_reg.sv
// -----------------------------------------------------------------------------
// lane_bit_write_reg
// Multi-lane register bank with whole-lane operations and a single-bit
// indexed write.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   lane_clr     per-lane synchronous clear to the lane slice of RST_VAL
//   lane_we      per-lane operation enable
//   lane_op      per-lane operation, 2 bits per lane (lane_op_e)
//   d            data/mask, lane i uses d[i*LANE_W +: LANE_W]
//   bit_we       single-bit write enable
//   bit_idx      bit index; values >= WIDTH are out of range
//   bit_val      value written to q[bit_idx]
//   dirty_clr    per-lane dirty flag clear
//   q            register contents
//   dirty        per-lane "modified since last clear" flags
//   idx_err      one-cycle pulse after an out-of-range bit write
// -----------------------------------------------------------------------------
module lane_bit_write_reg
  import lane_bit_write_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               LANES   = 2,
  parameter int               LANE_W  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              IDX_W   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LANES-1:0]   lane_clr,
  input  logic [LANES-1:0]   lane_we,
  input  logic [2*LANES-1:0] lane_op,
  input  logic [WIDTH-1:0]   d,
  input  logic               bit_we,
  input  logic [IDX_W-1:0]   bit_idx,
  input  logic               bit_val,
  input  logic [LANES-1:0]   dirty_clr,
  output logic [WIDTH-1:0]   q,
  output logic [LANES-1:0]   dirty,
  output logic               idx_err
);

  if (WIDTH != LANES * LANE_W) begin : g_bad_param
    $error("lane_bit_write_reg: WIDTH must equal LANES*LANE_W");
  end

  logic [WIDTH-1:0] bit_hit_s;
  logic             idx_oob_s;
  logic             idx_err_q;
  logic             idx_err_d;

  // One-hot decode of the bit index; an out-of-range index hits nothing.
  always_comb begin
    idx_oob_s = (bit_idx >= IDX_W'(WIDTH));
    for (int j = 0; j < WIDTH; j++) begin
      bit_hit_s[j] = bit_we & ~idx_oob_s & (bit_idx == IDX_W'(j));
    end
    idx_err_d = bit_we & idx_oob_s;
  end

  // Out-of-range flag: a single-cycle pulse, cleared whenever no error occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_err_q <= 1'b0;
    end else begin
      idx_err_q <= idx_err_d;
    end
  end

  assign idx_err = idx_err_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_bit_write_slice #(
      .LANE_W  (LANE_W),
      .RST_VAL (RST_VAL[i*LANE_W +: LANE_W])
    ) u_slice (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (lane_clr[i]),
      .we_i        (lane_we[i]),
      .op_i        (lane_op_e'(lane_op[2*i +: 2])),
      .d_i         (d[i*LANE_W +: LANE_W]),
      .bit_hit_i   (bit_hit_s[i*LANE_W +: LANE_W]),
      .bit_val_i   (bit_val),
      .dirty_clr_i (dirty_clr[i]),
      .q_o         (q[i*LANE_W +: LANE_W]),
      .dirty_o     (dirty[i])
    );
  end

endmodule

// File: tb/tb_lane_bit_write_reg.sv
module tb_lane_bit_write_reg;

  localparam int W  = 8;
  localparam int L  = 2;
  localparam int LW = 4;

  logic         clk;
  logic         rst_n;
  logic [L-1:0] lane_clr;
  logic [L-1:0] lane_we;
  logic [2*L-1:0] lane_op;
  logic [W-1:0] d;
  logic         bit_we;
  logic [3:0]   bit_idx;
  logic         bit_val;
  logic [L-1:0] dirty_clr;
  logic [W-1:0] q;
  logic [L-1:0] dirty;
  logic         idx_err;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [W-1:0] mq;
  logic [L-1:0] md;
  logic         merr;

  lane_bit_write_reg #(.WIDTH(W), .LANES(L), .LANE_W(LW), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .lane_clr(lane_clr), .lane_we(lane_we),
    .lane_op(lane_op), .d(d), .bit_we(bit_we), .bit_idx(bit_idx),
    .bit_val(bit_val), .dirty_clr(dirty_clr), .q(q), .dirty(dirty),
    .idx_err(idx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    lane_clr = '0; lane_we = '0; lane_op = '0; d = '0;
    bit_we = 1'b0; bit_idx = 4'd0; bit_val = 1'b0; dirty_clr = '0;
  endtask

  task automatic model_reset();
    mq = 8'h00; md = 2'b00; merr = 1'b0;
  endtask

  // Reference: apply the lane rules arithmetically to the sampled inputs.
  task automatic model_update();
    logic [W-1:0] nq;
    logic [L-1:0] nd;
    for (int i = 0; i < L; i++) begin
      int cur, dv, op, nv;
      cur = (mq >> (i*LW)) & 15;
      dv  = (d  >> (i*LW)) & 15;
      op  = (lane_op >> (2*i)) & 3;
      nv  = cur;
      if (lane_clr[i]) nv = 0;
      else begin
        if (lane_we[i]) begin
          if (op == 0)      nv = dv;
          else if (op == 1) nv = cur | dv;
          else if (op == 2) nv = cur & ~dv & 15;
          else              nv = cur ^ dv;
        end
        if (bit_we && bit_idx < W && (int'(bit_idx) / LW) == i) begin
          if (bit_val) nv = nv | (1 << (int'(bit_idx) % LW));
          else         nv = nv & ~(1 << (int'(bit_idx) % LW)) & 15;
        end
      end
      nq[i*LW +: LW] = nv[LW-1:0];
      nd[i] = (nv != cur) || (md[i] && !dirty_clr[i]);
    end
    mq = nq; md = nd;
    merr = bit_we && (bit_idx >= W);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if (dirty !== 2'b00) begin errors++; $display("FAIL reset_dirty: got %b want 00", dirty); end
    checks++; if (idx_err !== 1'b0) begin errors++; $display("FAIL reset_idx_err: got %b want 0", idx_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    // LOAD lane1
    idle(); lane_we = 2'b10; lane_op = 4'b0000; d = 8'hA0; step();
    checks++; if (q !== 8'hA0) begin errors++; $display("FAIL load_q: got %h want a0", q); end
    checks++; if (dirty !== 2'b10) begin errors++; $display("FAIL load_dirty: got %b want 10", dirty); end
    // SET lane0
    idle(); lane_we = 2'b01; lane_op = 4'b0001; d = 8'h05; step();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL set_q: got %h want a5", q); end
    checks++; if (dirty !== 2'b11) begin errors++; $display("FAIL set_dirty: got %b want 11", dirty); end
    // TGL lane0 with bit 2 forced to 0
    idle(); lane_we = 2'b01; lane_op = 4'b0011; d = 8'h0F;
    bit_we = 1'b1; bit_idx = 4'd2; bit_val = 1'b0; step();
    checks++; if (q !== 8'hAA) begin errors++; $display("FAIL tgl_bit_q: got %h want aa", q); end
    // Bit write overriding op result: TGL lane0 by 1, bit0 forced 0
    idle(); lane_we = 2'b01; lane_op = 4'b0011; d = 8'h01;
    bit_we = 1'b1; bit_idx = 4'd0; bit_val = 1'b0; step();
    checks++; if (q !== 8'hAA) begin errors++; $display("FAIL bit_override_q: got %h want aa", q); end
    // Clear lane1 beats bit write to bit 7
    idle(); lane_clr = 2'b10; bit_we = 1'b1; bit_idx = 4'd7; bit_val = 1'b1; step();
    checks++; if (q !== 8'h0A) begin errors++; $display("FAIL clr_beats_bit_q: got %h want 0a", q); end
    checks++; if (dirty[1] !== 1'b1) begin errors++; $display("FAIL clr_dirty1: got %b want 1", dirty[1]); end
  endtask

  task automatic test_idx_err();
    idle(); bit_we = 1'b1; bit_idx = 4'd9; bit_val = 1'b1; step();
    checks++; if (q !== 8'h0A) begin errors++; $display("FAIL oob_q: got %h want 0a", q); end
    checks++; if (idx_err !== 1'b1) begin errors++; $display("FAIL oob_err: got %b want 1", idx_err); end
    idle(); step();
    checks++; if (idx_err !== 1'b0) begin errors++; $display("FAIL oob_err_pulse: got %b want 0", idx_err); end
    idle(); bit_we = 1'b1; bit_idx = 4'd8; bit_val = 1'b1; step();
    checks++; if (idx_err !== 1'b1 || q !== 8'h0A) begin errors++; $display("FAIL oob_idx8: got err=%b q=%h want err=1 q=0a", idx_err, q); end
  endtask

  task automatic test_dirty();
    // Clear both flags while lane0 changes: set wins on lane0
    idle(); dirty_clr = 2'b11; lane_we = 2'b01; lane_op = 4'b0001; d = 8'h01; step();
    checks++; if (q !== 8'h0B) begin errors++; $display("FAIL dclr_set_q: got %h want 0b", q); end
    checks++; if (dirty !== 2'b01) begin errors++; $display("FAIL dclr_set_dirty: got %b want 01", dirty); end
    idle(); dirty_clr = 2'b11; step();
    checks++; if (dirty !== 2'b00) begin errors++; $display("FAIL dclr_dirty: got %b want 00", dirty); end
    // Value-preserving LOAD does not mark lane dirty
    idle(); lane_we = 2'b11; lane_op = 4'b0000; d = 8'h0B; step();
    checks++; if (dirty !== 2'b00 || q !== 8'h0B) begin errors++; $display("FAIL preserve_dirty: got dirty=%b q=%h want 00 0b", dirty, q); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      lane_clr  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      lane_we   = 2'($urandom);
      lane_op   = 4'($urandom);
      d         = 8'($urandom);
      bit_we    = 1'($urandom);
      bit_idx   = 4'($urandom_range(0, 15));
      bit_val   = 1'($urandom);
      dirty_clr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      step();
      checks++; if (q !== mq) begin errors++; $display("FAIL rand_q[%0d]: got %h want %h", n, q, mq); end
      checks++; if (dirty !== md) begin errors++; $display("FAIL rand_dirty[%0d]: got %b want %b", n, dirty, md); end
      checks++; if (idx_err !== merr) begin errors++; $display("FAIL rand_idx_err[%0d]: got %b want %b", n, idx_err, merr); end
    end
  endtask

  task automatic test_async_reset();
    // Get non-reset state with activity in flight
    idle(); lane_we = 2'b11; lane_op = 4'b0000; d = 8'h5C; bit_we = 1'b1; bit_idx = 4'd12; step();
    checks++; if (q !== 8'h5C || idx_err !== 1'b1) begin errors++; $display("FAIL pre_reset: got q=%h err=%b want 5c 1", q, idx_err); end
    @(negedge clk); #2;
    rst_n = 1'b0; model_reset();
    #1;
    checks++; if (q !== 8'h00 || dirty !== 2'b00 || idx_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got q=%h dirty=%b err=%b want 00 00 0", q, dirty, idx_err); end
    @(posedge clk); #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_hold_q: got %h want 00", q); end
    @(negedge clk); rst_n = 1'b1;
    idle(); lane_we = 2'b01; lane_op = 4'b0001; d = 8'h03; step();
    checks++; if (q !== 8'h03 || dirty !== 2'b01) begin errors++; $display("FAIL post_reset: got q=%h dirty=%b want 03 01", q, dirty); end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_directed();
    test_idx_err();
    test_dirty();
    test_random();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
